// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stall, bubble, flush and back-end hold
// decisions, memory-wait watchdog and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_Rd_i,
    input  logic [4:0]       IFID_Rs1_i,
    input  logic [4:0]       IFID_Rs2_i,
    input  logic             Branch_taken_i,
    input  logic             Mem_req_i,
    input  logic             Mem_ack_i,
    output logic             PC_Write_o,
    output logic             IFID_Write_o,
    output logic             IFID_Flush_o,
    output logic             IDEX_Bubble_o,
    output logic             Pipe_Hold_o,
    output logic             Err_o,
    output logic [CNT_W-1:0] Stall_cnt_o,
    output logic [CNT_W-1:0] Flush_cnt_o
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             load_use;
    logic             held;
    logic             active;

    assign load_use = IDEX_MemRead_i && (IDEX_Rd_i != 5'd0) &&
                      ((IDEX_Rd_i == IFID_Rs1_i) ||
                       (IDEX_Rd_i == IFID_Rs2_i));
    assign active   = (state_q == S_RUN) || (state_q == S_WAIT);

    // Next state, watchdog and zero-latency hazard outputs.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        held          = 1'b0;
        PC_Write_o    = 1'b0;
        IFID_Write_o  = 1'b0;
        IFID_Flush_o  = 1'b0;
        IDEX_Bubble_o = 1'b0;
        Pipe_Hold_o   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                IDEX_Bubble_o = 1'b1;
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                held = Mem_req_i && !Mem_ack_i;
                if (held) begin
                    state_d = S_WAIT;
                    wait_d  = WCW'(1);
                end else if (!start_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                held = !Mem_ack_i;
                if (Mem_ack_i) begin
                    state_d = S_RUN;
                    wait_d  = '0;
                end else if (wait_q == WCW'(MEM_TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end
            S_ERR: begin
                IDEX_Bubble_o = 1'b1;
                Pipe_Hold_o   = 1'b1;
            end
        endcase
        // A pending memory access masks load-use and branch until release.
        if (active) begin
            if (held) begin
                Pipe_Hold_o = 1'b1;
            end else if (load_use) begin
                IDEX_Bubble_o = 1'b1;
            end else if (Branch_taken_i) begin
                PC_Write_o   = 1'b1;
                IFID_Write_o = 1'b1;
                IFID_Flush_o = 1'b1;
            end else begin
                PC_Write_o   = 1'b1;
                IFID_Write_o = 1'b1;
            end
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (active && !PC_Write_o && (stall_q != '1))
            stall_d = stall_q + CNT_W'(1);
        if (IFID_Flush_o && (flush_q != '1))
            flush_d = flush_q + CNT_W'(1);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign Err_o       = (state_q == S_ERR);
    assign Stall_cnt_o = stall_q;
    assign Flush_cnt_o = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed plan scenarios plus random
// stimulus against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n, start, mr, br, req, ack;
    logic [4:0]    rd, rs1, rs2;
    logic          pc_w, ifid_w, flush, bub, hold, err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: 0 idle, 1 run, 2 mem wait, 3 error
    int m_mode, m_waited, m_stall, m_flush;
    bit e_pc, e_ifw, e_fl, e_bub, e_hold;
    // DUT combinational outputs captured in the last cycle
    bit c_pc, c_bub, c_fl, c_hold;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT(TO),
        .CNT_W      (CW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .start_i       (start),
        .IDEX_MemRead_i(mr),
        .IDEX_Rd_i     (rd),
        .IFID_Rs1_i    (rs1),
        .IFID_Rs2_i    (rs2),
        .Branch_taken_i(br),
        .Mem_req_i     (req),
        .Mem_ack_i     (ack),
        .PC_Write_o    (pc_w),
        .IFID_Write_o  (ifid_w),
        .IFID_Flush_o  (flush),
        .IDEX_Bubble_o (bub),
        .Pipe_Hold_o   (hold),
        .Err_o         (err),
        .Stall_cnt_o   (stall_cnt),
        .Flush_cnt_o   (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Expected decode outputs for the current model mode and inputs.
    task automatic model_comb(output bit memwait);
        bit lu;
        lu = mr && rd != 0 && (rd == rs1 || rd == rs2);
        memwait = 0;
        {e_pc, e_ifw, e_fl, e_bub, e_hold} = 5'b0;
        if (m_mode == 0) begin
            e_bub = 1;
        end else if (m_mode == 3) begin
            e_bub  = 1;
            e_hold = 1;
        end else begin
            memwait = (m_mode == 1) ? (req && !ack) : !ack;
            if (memwait) e_hold = 1;
            else if (lu) e_bub = 1;
            else begin
                e_pc  = 1;
                e_ifw = 1;
                e_fl  = br;
            end
        end
    endtask

    task automatic cyc();
        bit mw;
        #1;
        model_comb(mw);
        c_pc   = pc_w;
        c_bub  = bub;
        c_fl   = flush;
        c_hold = hold;
        chk("pc_write", pc_w, e_pc);
        chk("ifid_write", ifid_w, e_ifw);
        chk("ifid_flush", flush, e_fl);
        chk("idex_bubble", bub, e_bub);
        chk("pipe_hold", hold, e_hold);
        @(posedge clk);
        if (!rst_n) begin
            m_mode   = 0;
            m_waited = 0;
            m_stall  = 0;
            m_flush  = 0;
        end else begin
            if ((m_mode == 1 || m_mode == 2) && !e_pc)
                m_stall = sat(m_stall + 1);
            if (e_fl) m_flush = sat(m_flush + 1);
            case (m_mode)
                0: if (start) m_mode = 1;
                1: if (mw) begin
                    m_mode   = 2;
                    m_waited = 1;
                end else if (!start) m_mode = 0;
                2: if (ack) begin
                    m_mode   = 1;
                    m_waited = 0;
                end else if (m_waited == TO - 1) m_mode = 3;
                else m_waited++;
                default: ;
            endcase
        end
        #1;
        chk("err", err, m_mode == 3);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
    endtask

    task automatic quiet();
        rst_n = 1; start = 1; mr = 0; br = 0; req = 0; ack = 0;
        rd = 0; rs1 = 0; rs2 = 0;
    endtask

    task automatic do_reset();
        quiet();
        start = 0;
        rst_n = 0;
        cyc();
        rst_n = 1;
    endtask

    task automatic go_run();
        quiet();
        cyc();
    endtask

    initial begin
        m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0;
        quiet();
        do_reset();
        // idle after reset, start low
        for (int i = 0; i < 3; i++) begin
            start = 0;
            cyc();
            chk("idle_bubble", c_bub, 1);
            chk("idle_pc", c_pc, 0);
        end
        start = 1;
        cyc();
        chk("start_cyc1_pc", c_pc, 0);
        cyc();
        chk("start_cyc2_pc", c_pc, 1);

        // load-use stall, then rd=0 gives no stall
        mr = 1; rd = 5; rs2 = 5; rs1 = 3;
        cyc();
        chk("lu_pc", c_pc, 0);
        chk("lu_bubble", c_bub, 1);
        chk("lu_stall_cnt", stall_cnt, 1);
        rd = 0; rs2 = 0;
        cyc();
        chk("lu_rd0_pc", c_pc, 1);
        quiet();

        // two taken branches, then branch with load-use
        br = 1;
        cyc();
        cyc();
        chk("br_flush", c_fl, 1);
        chk("br_flush_cnt", flush_cnt, 2);
        mr = 1; rd = 7; rs1 = 7;
        cyc();
        chk("lu_br_flush", c_fl, 0);
        chk("lu_br_flush_cnt", flush_cnt, 2);
        chk("lu_br_stall_cnt", stall_cnt, 2);
        quiet();

        // memory wait with ack on the 4th cycle
        req = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("mw_hold", c_hold, 1);
        end
        ack = 1;
        cyc();
        chk("mw_ack_hold", c_hold, 0);
        chk("mw_ack_pc", c_pc, 1);
        chk("mw_stall_cnt", stall_cnt, 5);
        quiet();
        cyc();
        chk("mw_back_run", c_pc, 1);

        // watchdog timeout
        req = 1;
        for (int i = 0; i < TO; i++) cyc();
        chk("to_err", err, 1);
        cyc();
        chk("to_frozen_hold", c_hold, 1);
        chk("to_frozen_pc", c_pc, 0);
        do_reset();
        chk("rst_err", err, 0);
        chk("rst_stall", stall_cnt, 0);

        // stall counter saturation
        go_run();
        mr = 1; rd = 9; rs1 = 9;
        for (int i = 0; i < 20; i++) cyc();
        chk("sat_stall", stall_cnt, CMAX);
        cyc();
        chk("sat_stall_hold", stall_cnt, CMAX);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            start = ($urandom_range(0, 9) != 0);
            mr    = $urandom_range(0, 1);
            rd    = 5'($urandom_range(0, 3));
            rs1   = 5'($urandom_range(0, 3));
            rs2   = 5'($urandom_range(0, 3));
            br    = ($urandom_range(0, 3) == 0);
            req   = ($urandom_range(0, 3) == 0);
            ack   = ($urandom_range(0, 2) != 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
